acc_fixed_point: RTL and testbench
==================================

Name: acc_fixed_point

Overview:
Streaming Q7.8 saturating accumulator. It is the addition-side companion to the fixed-point subtract unit. It sums a group of signed Q7.8 samples arriving over a valid/ready input stream; the last sample of a group is marked by in_last. It then presents the saturated sum, a beat count and N/V/Z flags on a valid/ready output stream. It sits in the Execution stage behind the operand fetch, feeding reduction results to writeback.

Parameters:
DATA_WIDTH, 16, sample/accumulator width; Q7.8 when 16
FRAC_BITS, 8, fractional bits (informational; binary point does not move in addition)
CNT_WIDTH, 8, width of beat counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort: discard partial group and any pending result
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_WIDTH  signed Q7.8 sample
in_last  in  1  sample closes the current group
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_WIDTH  saturated signed sum
out_count  out  CNT_WIDTH  samples in group, saturating at 2^CNT_WIDTH-1
N  out  1  out_data[DATA_WIDTH-1]
V  out  1  sticky: any saturation occurred in the group
Z  out  1  out_data == 0

Behaviour:
- Reset (async, rst=1): state IDLE; acc=0, cnt=0, ovf=0; out_valid=0, out_data=0, out_count=0, N=0, V=0, Z=0. in_ready=0 while rst is high, and 1 in the first cycle after release.
- FSM states: IDLE, ACCUM, HOLD.
- in_ready = (state != HOLD) && !clear. A beat is accepted when in_valid && in_ready.
- IDLE + accept: acc <= in_data, cnt <= 1, ovf <= 0. Go to HOLD if in_last, else ACCUM.
- ACCUM + accept: acc <= sat(acc + in_data), cnt <= cnt+1 (holds at max), ovf <= ovf | overflow. Go to HOLD if in_last.
- Saturating add:
  - Compute a DATA_WIDTH+1 bit sum.
  - Overflow = operand signs equal and result sign differs.
  - Positive overflow gives 0x7FFF; negative overflow gives 0x8000.
  - The integer and fraction fields are never split; this is one two's-complement add.
- Entering HOLD: out_data, out_count, N, V and Z are registered from the final acc/cnt/ovf (including the closing beat), and out_valid=1. Latency: out_valid rises on the clock edge after the in_last beat is accepted, i.e. it is visible in the next cycle.
- HOLD:
  - out_* are stable while out_valid=1 and out_ready=0; in_ready=0.
  - On out_valid && out_ready: go to IDLE, out_valid=0 next cycle, acc/cnt/ovf cleared.
  - There is no same-cycle restart, so there is one bubble cycle between groups.
- Output registers keep their last values after out_valid falls; the flags are meaningful only while out_valid=1.
- clear (priority over everything except rst):
  - In any state: next state IDLE; acc, cnt, ovf and out_valid are cleared.
  - A beat presented in the same cycle is not accepted (in_ready=0).
- Simultaneous in_valid && in_last in IDLE gives a single-beat group (count 1).
- Count saturation does not set V; V reflects data saturation only.
- Once the accumulator saturates it keeps summing from the saturated value; later opposite-sign beats bring it back into range, and V stays 1.
- rst mid-group or in HOLD drops all state immediately.

Decomposition:
- fixed_point_pkg:
  - DATA_WIDTH, FRAC_BITS
  - Q_MAX=16'h7FFF, Q_MIN=16'h8000
  - typedef q7_8_t (logic signed [15:0])
  - enum acc_state_t {IDLE, ACCUM, HOLD}
- One combinational sub-module, sat_add_fixed_point (a, b -> sum, ovf). It is reusable by the subtract path via negated b.

Test Plan:
- Single beat: 0x0180 (1.5) with in_last in IDLE -> next cycle out_valid=1, out_data=0x0180, out_count=1, N=0, V=0, Z=0.
- Group of 0x0180, 0x0240, 0xFC40 (1.5 + 2.25 - 3.75) -> out_data=0x0000, count=3, Z=1, N=0, V=0.
- Positive saturation:
  - 0x7000, 0x7000 (last) -> 0x7FFF, V=1.
  - 0x7000, 0x7000, 0x9000 (last) -> 0x0FFF, V=1 (sticky), N=0.
- Negative saturation: 0x8100, 0x8100 (last) -> 0x8000, N=1, V=1, Z=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_valid=1, out_data stable, in_ready=0 throughout. out_ready=1 -> IDLE, in_ready=1 next cycle, then the next group accumulates from 0.
- Abort:
  - clear during ACCUM after 0x0100, 0x0100 -> no out_valid; the next group 0x0080 (last) gives 0x0080, count=1.
  - rst asserted asynchronously in HOLD -> out_valid=0 immediately, all outputs zero.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared Q7.8 types, saturation limits and accumulator states for the fixed-point datapath.
package fixed_point_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  typedef logic signed [15:0] q7_8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/sat_add_fixed_point.sv
// Combinational saturating two's-complement add, zero latency; the subtract path reuses it
// by feeding a negated b. No flow control.
module sat_add_fixed_point #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Same-sign operands producing a result of the other sign cannot be represented.
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    if (!ovf)
      sum = raw[WIDTH-1:0];
    else if (a[WIDTH-1])
      sum = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sum = {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/acc_fixed_point.sv
// Streaming Q7.8 saturating group accumulator: result valid the cycle after the in_last beat,
// held until out_ready; input stalls (in_ready=0) while a result is pending or clear is high.
module acc_fixed_point
  import fixed_point_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  N,
  output logic                  V,
  output logic                  Z
);

  if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must leave at least one integer bit");
  end

  acc_state_t             state;
  logic [DATA_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   ovf;

  logic [DATA_WIDTH-1:0]  add_sum;
  logic                   add_ovf;
  logic [DATA_WIDTH-1:0]  nxt_acc;
  logic [CNT_WIDTH-1:0]   nxt_cnt;
  logic                   nxt_ovf;
  logic                   accept;

  sat_add_fixed_point #(.WIDTH(DATA_WIDTH)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready = !rst && (state != HOLD) && !clear;
  assign accept   = in_valid && in_ready;

  // The first beat of a group loads directly so a stale acc can never leak in.
  always_comb begin
    nxt_acc = add_sum;
    nxt_cnt = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;
    nxt_ovf = ovf | add_ovf;
    if (state == IDLE) begin
      nxt_acc = in_data;
      nxt_cnt = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      nxt_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      N         <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= nxt_acc;
            cnt <= nxt_cnt;
            ovf <= nxt_ovf;
            if (in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= nxt_acc;
              out_count <= nxt_cnt;
              N         <= nxt_acc[DATA_WIDTH-1];
              V         <= nxt_ovf;
              Z         <= (nxt_acc == '0);
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_fixed_point.sv
// Directed-vector bench for acc_fixed_point with hand-computed Q7.8 results.
module tb_acc_fixed_point;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        N, V, Z;

  int n_cmp = 0;
  int n_bad = 0;

  acc_fixed_point #(.DATA_WIDTH(16), .FRAC_BITS(8), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .N         (N),
    .V         (V),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  // Presents one beat; returns at posedge+1 with in_valid dropped.
  task automatic beat(input logic [15:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (waited >= 50) begin
      n_bad++;
      $display("FAIL beat_timeout: in_ready stuck low, data=%h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z, in_ready} !== 29'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%0d NVZ=%b%b%b rdy=%b, want all zero",
               out_valid, out_data, out_count, N, V, Z, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    beat(16'h0180, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h0180, 8'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL single_beat: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 0180 1 000",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
  endtask

  task automatic test_group_zero();
    beat(16'h0180, 1'b0);
    beat(16'h0240, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL group_midway_valid: got %b want 0", out_valid);
    end
    beat(16'hFC40, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h0000, 8'd3, 3'b001}) begin
      n_bad++;
      $display("FAIL group_zero: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 0000 3 001",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
  endtask

  task automatic test_pos_sat();
    beat(16'h7000, 1'b0);
    beat(16'h7000, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h7FFF, 8'd2, 3'b010}) begin
      n_bad++;
      $display("FAIL pos_sat: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 7fff 2 010",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
    beat(16'h7000, 1'b0);
    beat(16'h7000, 1'b0);
    beat(16'h9000, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h0FFF, 8'd3, 3'b010}) begin
      n_bad++;
      $display("FAIL pos_sat_sticky: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 0fff 3 010",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
  endtask

  task automatic test_neg_sat();
    beat(16'h8100, 1'b0);
    beat(16'h8100, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h8000, 8'd2, 3'b110}) begin
      n_bad++;
      $display("FAIL neg_sat: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 8000 2 110",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
  endtask

  task automatic test_backpressure();
    beat(16'hFF80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_valid, out_data, out_count, N, in_ready} !== {1'b1, 16'hFF80, 8'd1, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: got v=%b d=%h c=%0d N=%b rdy=%b want 1 ff80 1 1 0",
                 i, out_valid, out_data, out_count, N, in_ready);
      end
      @(posedge clk); #1;
    end
    drain();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL backpressure_release: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    beat(16'h0010, 1'b0);
    beat(16'h0020, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, V} !== {1'b1, 16'h0030, 8'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL after_release_group: got v=%b d=%h c=%0d V=%b want 1 0030 2 0",
               out_valid, out_data, out_count, V);
    end
    drain();
  endtask

  task automatic test_clear();
    beat(16'h0100, 1'b0);
    beat(16'h0100, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0500;
    in_last  = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_blocks_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_no_result[%0d]: got v=%b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    beat(16'h0080, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, V} !== {1'b1, 16'h0080, 8'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL after_clear_group: got v=%b d=%h c=%0d V=%b want 1 0080 1 0",
               out_valid, out_data, out_count, V);
    end
    drain();
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 299; i++) beat(16'h0000, 1'b0);
    beat(16'h0000, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z} !== {1'b1, 16'h0000, 8'd255, 3'b001}) begin
      n_bad++;
      $display("FAIL count_sat: got v=%b d=%h c=%0d NVZ=%b%b%b want 1 0000 255 001",
               out_valid, out_data, out_count, N, V, Z);
    end
    drain();
  endtask

  task automatic test_rst_in_hold();
    beat(16'h8123, 1'b1);
    n_cmp++;
    if ({out_valid, N} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_rst_hold: got v=%b N=%b want 1 1", out_valid, N);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_count, N, V, Z, in_ready} !== 29'h0) begin
      n_bad++;
      $display("FAIL rst_in_hold: got v=%b d=%h c=%0d NVZ=%b%b%b rdy=%b want all zero",
               out_valid, out_data, out_count, N, V, Z, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat(16'h0001, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, out_count} !== {1'b1, 16'h0001, 8'd1}) begin
      n_bad++;
      $display("FAIL after_rst_group: got v=%b d=%h c=%0d want 1 0001 1",
               out_valid, out_data, out_count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_group_zero();
    test_pos_sat();
    test_neg_sat();
    test_backpressure();
    test_clear();
    test_count_sat();
    test_rst_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
